// File: rtl/kronos_execute.sv
// kronos_execute: Kronos execute stage, ID->EX consumer with registered valid/ready result output.
//   clk, rstz (async active-low) | decode[83:0] (pipeIDEX_t), decode_vld, decode_rdy
//   execute_result[31:0], execute_vld, execute_rdy | execute_busy (iterative shift in flight)
//   KRONOS_FAST_SHIFT_EN: barrel shifter, no FSM, execute_busy tied 0.
module kronos_execute #(
  parameter logic [31:0] RESET_RESULT = 32'h0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [83:0] decode,
  input  logic        decode_vld,
  output logic        decode_rdy,
  output logic [31:0] execute_result,
  output logic        execute_vld,
  input  logic        execute_rdy,
  output logic        execute_busy
);
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        rs1_read;
    logic        rs2_read;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        neg;
    logic        rev;
    logic        cin;
    logic        uns;
    logic        gte;
    logic [2:0]  sel;
  } pipeIDEX_t;
  pipeIDEX_t d;
  logic [31:0] alu, sum, shifted, shift_res, res_q, res_d;
  logic [4:0] shamt;
  logic lt, idle, accept, shift_start, shift_done, vld_q, vld_d;
  logic unused_fields;
  assign d = decode;
  assign unused_fields = ^{d.rs1_read, d.rs2_read, d.rs1, d.rs2};
  assign shamt = d.op2[4:0];
  assign decode_rdy = idle & (~vld_q | execute_rdy);
  assign accept = decode_vld & decode_rdy;
  assign execute_vld = vld_q;
  assign execute_result = res_q;
`ifdef KRONOS_FAST_SHIFT_EN
  assign shifted = d.rev ? d.op1 << shamt :
                   d.uns ? d.op1 >> shamt : $unsigned($signed(d.op1) >>> shamt);
  assign idle = 1'b1;
  assign shift_start = 1'b0;
  assign shift_done = 1'b0;
  assign shift_res = 32'h0;
  assign execute_busy = 1'b0;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [4:0] cnt_q, cnt_d;
  logic rev_q, rev_d, uns_q, uns_d;
  // only shamt==0 reaches the output directly; non-zero shifts go through the FSM
  assign shifted = d.op1;
  assign idle = state_q == IDLE;
  assign shift_start = accept & (d.sel == 3'd5) & (|shamt);
  assign shift_done = (state_q == SHIFT) & (cnt_q == 5'd1);
  assign shift_res = rev_q ? {shreg_q[30:0], 1'b0} : {~uns_q & shreg_q[31], shreg_q[31:1]};
  assign execute_busy = state_q == SHIFT;
  always_comb begin
    state_d = shift_start ? SHIFT : shift_done ? IDLE : state_q;
    shreg_d = shift_start ? d.op1 : (state_q == SHIFT) ? shift_res : shreg_q;
    cnt_d = shift_start ? shamt : (state_q == SHIFT) ? cnt_q - 5'd1 : cnt_q;
    rev_d = shift_start ? d.rev : rev_q;
    uns_d = shift_start ? d.uns : uns_q;
  end
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      shreg_q <= 32'h0;
      cnt_q <= 5'd0;
      rev_q <= 1'b0;
      uns_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      rev_q <= rev_d;
      uns_q <= uns_d;
    end
  end
`endif
  always_comb begin
    sum = d.op1 + (d.neg ? ~d.op2 : d.op2) + {31'b0, d.cin};
    lt = d.uns ? (d.op1 < d.op2) : ($signed(d.op1) < $signed(d.op2));
    alu = (d.sel == 3'd0) ? sum :
          (d.sel == 3'd1) ? d.op1 & d.op2 :
          (d.sel == 3'd2) ? d.op1 | d.op2 :
          (d.sel == 3'd3) ? d.op1 ^ d.op2 :
          (d.sel == 3'd4) ? {31'b0, d.gte ? ~lt : lt} :
          (d.sel == 3'd5) ? shifted : 32'h0;
  end
  // a load in the same edge as a consume keeps execute_vld high
  always_comb begin
    vld_d = (accept & ~shift_start) | shift_done | (vld_q & ~execute_rdy);
    res_d = shift_done ? shift_res : (accept & ~shift_start) ? alu : res_q;
  end
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      vld_q <= 1'b0;
      res_q <= RESET_RESULT;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end
endmodule
